n64_bank_router: RTL and testbench

Downstream stage of the N64 PI slave. Accepts the single-outstanding bus request produced by the PI front end (request/write/bank/address/data with busy/ack handshake) and forwards it to exactly one of NUM_BANKS target ports. Returns read data and an ack pulse upstream. Handles unmapped banks and stalled targets with a fixed-value timeout response, so the PI never hangs.

---
 rtl/n64_bank_router.sv | 148 ++++++++++++++
 tb/tb_n64_bank_router.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/n64_bank_router.sv
// Routes the single outstanding PI request to one bank target and returns
// read data; unmapped banks and stalled targets complete with 32'hFFFF_FFFF.
module n64_bank_router #(
  parameter int NUM_BANKS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_request,
  input  logic                    i_write,
  input  logic [3:0]              i_bank,
  input  logic [25:0]             i_address,
  input  logic [31:0]             i_data,
  output logic                    o_busy,
  output logic                    o_ack,
  output logic [31:0]             o_data,
  output logic                    o_timeout,
  output logic [NUM_BANKS-1:0]    o_target_request,
  output logic                    o_target_write,
  output logic [25:0]             o_target_address,
  output logic [31:0]             o_target_data,
  input  logic [NUM_BANKS-1:0]    i_target_busy,
  input  logic [NUM_BANKS-1:0]    i_target_ack,
  input  logic [32*NUM_BANKS-1:0] i_target_data
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_UNMAPPED} state_t;

  state_t               state_q, state_d;
  logic [NUM_BANKS-1:0] sel_q, sel_d;
  logic                 write_q, write_d;
  logic [25:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ack_q, ack_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_BANKS-1:0] in_hit;
  logic [31:0]          sel_data;
  logic                 sel_busy, sel_ack;

  // Bank code 0 is never a target, so its one-hot bit is tied low.
  assign in_hit[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_BANKS; gi++) begin : g_hit
    assign in_hit[gi] = (i_bank == 4'(gi));
  end

  // sel_q is one-hot on the latched bank; all-zero for an unmapped code.
  assign sel_busy = |(i_target_busy & sel_q);
  assign sel_ack  = |(i_target_ack & sel_q);

  always_comb begin
    sel_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (sel_q[b]) sel_data = sel_data | i_target_data[32*b +: 32];
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_request) begin
          sel_d   = in_hit;
          write_d = i_write;
          addr_d  = i_address;
          wdata_d = i_data;
          state_d = (|in_hit) ? S_ISSUE : S_UNMAPPED;
        end
      end
      S_ISSUE, S_WAIT_ACK: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // Timeout is checked first so it wins over a same-cycle ack.
        if (cnt_q >= CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
          if (!write_q) begin
            ack_d   = 1'b1;
            rdata_d = 32'hFFFF_FFFF;
          end
        end else if (state_q == S_ISSUE) begin
          if (!sel_busy) state_d = S_WAIT_ACK;
        end else if (sel_ack) begin
          state_d = S_IDLE;
          if (!write_q) begin
            ack_d   = 1'b1;
            rdata_d = sel_data;
          end
        end
      end
      S_UNMAPPED: begin
        state_d = S_IDLE;
        if (!write_q) begin
          ack_d   = 1'b1;
          rdata_d = 32'hFFFF_FFFF;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
    end
  end

  // The target request is decoded from state so a reset drops it at once.
  assign o_target_request = (state_q == S_ISSUE) ? sel_q : '0;
  assign o_busy           = (state_q != S_IDLE);
  assign o_ack            = ack_q;
  assign o_data           = rdata_q;
  assign o_timeout        = timeout_q;
  assign o_target_write   = write_q;
  assign o_target_address = addr_q;
  assign o_target_data    = wdata_q;
endmodule

// File: tb/tb_n64_bank_router.sv
// Bench for n64_bank_router: table of transactions with a behavioural target
// model and an expected-completion scoreboard, plus back-to-back and reset cases.
module tb_n64_bank_router;
  localparam int NB = 8;
  localparam int TO = 16;

  logic              clk;
  logic              i_reset, i_request, i_write;
  logic [3:0]        i_bank;
  logic [25:0]       i_address;
  logic [31:0]       i_data;
  logic              o_busy, o_ack, o_timeout;
  logic [31:0]       o_data;
  logic [NB-1:0]     o_target_request;
  logic              o_target_write;
  logic [25:0]       o_target_address;
  logic [31:0]       o_target_data;
  logic [NB-1:0]     i_target_busy, i_target_ack;
  logic [32*NB-1:0]  i_target_data;

  n64_bank_router #(.NUM_BANKS(NB), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_request(i_request), .i_write(i_write),
    .i_bank(i_bank), .i_address(i_address), .i_data(i_data),
    .o_busy(o_busy), .o_ack(o_ack), .o_data(o_data), .o_timeout(o_timeout),
    .o_target_request(o_target_request), .o_target_write(o_target_write),
    .o_target_address(o_target_address), .o_target_data(o_target_data),
    .i_target_busy(i_target_busy), .i_target_ack(i_target_ack),
    .i_target_data(i_target_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [3:0]  bank;
    logic [25:0] addr;
    logic [31:0] wdata;
    int          busy;      // cycles the target holds busy after acceptance
    int          ack_delay; // ack this many cycles after grant; 0 = never
    logic [31:0] tdata;
    int          spur;      // bank raising a stray ack one cycle after grant; 0 = none
    logic        e_ack;
    logic        e_to;
    logic [31:0] e_data;
    int          e_lat;     // cycle (after sampling) in which o_busy is low again
  } vec_t;

  typedef struct {
    logic        ack;
    logic        to;
    logic [31:0] data;
    int          lat;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_ack"}, 64'(o_ack), 64'd0);
    chk({tag, "_timeout"}, 64'(o_timeout), 64'd0);
    chk({tag, "_data"}, 64'(o_data), 64'd0);
    chk({tag, "_treq"}, 64'(o_target_request), 64'd0);
    chk({tag, "_twrite"}, 64'(o_target_write), 64'd0);
    chk({tag, "_taddr"}, 64'(o_target_address), 64'd0);
    chk({tag, "_tdata"}, 64'(o_target_data), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t          e;
    exp_t          got;
    int            c;
    int            g;
    int            req_err;
    bit            done;
    bit            mapped;
    logic [NB-1:0] want;
    tick();
    i_request = 1'b1;
    i_write   = v.write;
    i_bank    = v.bank;
    i_address = v.addr;
    i_data    = v.wdata;
    e.ack = v.e_ack; e.to = v.e_to; e.data = v.e_data; e.lat = v.e_lat;
    sb.push_back(e);
    tick();
    i_request = 1'b0;
    mapped  = (v.bank != 4'd0) && (int'(v.bank) < NB);
    want    = mapped ? NB'(1 << v.bank) : '0;
    g       = v.busy + 1;
    c       = 1;
    done    = 1'b0;
    req_err = 0;
    while (!done && c <= 60) begin
      i_target_busy = '0;
      i_target_ack  = '0;
      if (mapped && c <= v.busy) i_target_busy[v.bank] = 1'b1;
      if (mapped && v.ack_delay != 0 && c == g + v.ack_delay) begin
        i_target_ack[v.bank] = 1'b1;
        i_target_data[32*v.bank +: 32] = v.tdata;
      end
      if (v.spur != 0 && c == g + 1) i_target_ack[v.spur] = 1'b1;
      @(negedge clk);
      if (c == 1) begin
        chk("twrite", 64'(o_target_write), 64'(v.write));
        chk("taddr", 64'(o_target_address), 64'(v.addr));
        chk("tdata", 64'(o_target_data), 64'(v.wdata));
      end
      if (!o_busy) begin
        done = 1'b1;
        got  = sb.pop_front();
        chk("latency", 64'(c), 64'(got.lat));
        chk("ack", 64'(o_ack), 64'(got.ack));
        chk("timeout", 64'(o_timeout), 64'(got.to));
        if (got.ack) chk("rdata", 64'(o_data), 64'(got.data));
        $display("txn %0d: bank %0d %s done in cycle %0d ack=%0b timeout=%0b data=%h",
                 idx, v.bank, v.write ? "write" : "read", c, o_ack, o_timeout, o_data);
      end else begin
        if (o_target_request !== ((c <= g) ? want : '0)) req_err++;
        tick();
        c++;
      end
    end
    if (!done) begin
      chk("completion_bound", 64'd0, 64'd1);
      void'(sb.pop_front());
    end
    chk("treq_shape", 64'(req_err), 64'd0);
    tick();
    i_target_busy = '0;
    i_target_ack  = '0;
    @(negedge clk);
    chk("pulse_end", 64'({o_ack, o_timeout}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_request = 1'b0; i_write = 1'b0; i_bank = '0;
    i_address = '0; i_data = '0; i_target_busy = '0; i_target_ack = '0;
    for (int b = 0; b < NB; b++) i_target_data[32*b +: 32] = 32'hC0DE_0000 | 32'(b);

    vecs[0]  = '{1'b0, 4'd1,  26'h0000100, 32'h0,         0,  3,  32'hDEADBEEF, 0, 1'b1, 1'b0, 32'hDEADBEEF, 5};
    vecs[1]  = '{1'b1, 4'd3,  26'h0000200, 32'h12345678,  4,  2,  32'h0,        0, 1'b0, 1'b0, 32'h0,        8};
    vecs[2]  = '{1'b0, 4'd0,  26'h0000300, 32'h0,         0,  0,  32'h0,        0, 1'b1, 1'b0, 32'hFFFFFFFF, 2};
    vecs[3]  = '{1'b0, 4'd9,  26'h0000304, 32'h0,         0,  0,  32'h0,        0, 1'b1, 1'b0, 32'hFFFFFFFF, 2};
    vecs[4]  = '{1'b0, 4'd2,  26'h0000400, 32'h0,         0,  0,  32'h0,        0, 1'b1, 1'b1, 32'hFFFFFFFF, 17};
    vecs[5]  = '{1'b0, 4'd1,  26'h0000500, 32'h0,         0,  4,  32'h0BADF00D, 2, 1'b1, 1'b0, 32'h0BADF00D, 6};
    vecs[6]  = '{1'b0, 4'd5,  26'h0000600, 32'h0,         1,  3,  32'hA5A55A5A, 4, 1'b1, 1'b0, 32'hA5A55A5A, 6};
    vecs[7]  = '{1'b1, 4'd7,  26'h0000700, 32'h87654321,  0,  1,  32'h0,        0, 1'b0, 1'b0, 32'h0,        3};
    vecs[8]  = '{1'b1, 4'd6,  26'h0000800, 32'h55AA55AA,  20, 0,  32'h0,        0, 1'b0, 1'b1, 32'h0,        17};
    vecs[9]  = '{1'b1, 4'd15, 26'h0000900, 32'h01020304,  0,  0,  32'h0,        0, 1'b0, 1'b0, 32'h0,        2};
    vecs[10] = '{1'b0, 4'd3,  26'h0000A00, 32'h0,         0,  15, 32'h11111111, 0, 1'b1, 1'b1, 32'hFFFFFFFF, 17};
    vecs[11] = '{1'b0, 4'd4,  26'h3FFFFFF, 32'h0,         2,  1,  32'h00C0FFEE, 0, 1'b1, 1'b0, 32'h00C0FFEE, 5};

    @(negedge clk);
    check_reset("reset");
    tick();
    i_reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Back-to-back: a new request is sampled in the cycle o_ack is high.
    tick();
    i_request = 1'b1; i_write = 1'b0; i_bank = 4'd1; i_address = 26'h42;
    tick();
    i_request = 1'b0;
    tick();
    i_target_ack[1] = 1'b1;
    i_target_data[63:32] = 32'hCAFEF00D;
    tick();
    i_target_ack = '0;
    i_request = 1'b1; i_bank = 4'd0;
    @(negedge clk);
    chk("b2b_ack", 64'(o_ack), 64'd1);
    chk("b2b_data", 64'(o_data), 64'hCAFEF00D);
    chk("b2b_idle", 64'(o_busy), 64'd0);
    tick();
    i_request = 1'b0;
    @(negedge clk);
    chk("b2b_accepted", 64'({o_busy, o_ack}), 64'b10);
    tick();
    @(negedge clk);
    chk("b2b_second_ack", 64'(o_ack), 64'd1);
    chk("b2b_second_data", 64'(o_data), 64'hFFFFFFFF);
    $display("txn b2b: bank 1 read then bank 0 read ack=%0b data=%h", o_ack, o_data);

    // Reset while in WAIT_ACK aborts at once, before any clock edge.
    tick();
    i_request = 1'b1; i_write = 1'b0; i_bank = 4'd4; i_address = 26'h123;
    tick();
    i_request = 1'b0;
    tick();
    chk("pre_reset_busy", 64'(o_busy), 64'd1);
    i_reset = 1'b1;
    #1;
    check_reset("midreset");
    $display("txn midreset: reset asserted in WAIT_ACK busy=%0b", o_busy);
    tick();
    i_reset = 1'b0;
    run_vec(vecs[11], 11);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
